// File: rtl/fir_seq_pkg.sv
// fir_mac_sequencer shared types and constants.
// OPMODE encodings, FSM states and datapath widths.
package fir_seq_pkg;

   localparam int DATA_W = 18;
   localparam int P_W    = 48;

   localparam logic [7:0] OPM_IDLE      = 8'h00;
   localparam logic [7:0] OPM_MAC_FIRST = 8'h01;
   localparam logic [7:0] OPM_MAC_ACC   = 8'h09;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      HOLD
   } state_t;

endpackage

// File: rtl/fir_mac_sequencer_tap_buffer.sv
// Sample history shift register and coefficient file.
// Both are read combinationally at the same index.
module fir_tap_buffer
   import fir_seq_pkg::*;
#(
   parameter int TAPS = 8,
   localparam int AW = $clog2(TAPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              shift,
   input  logic [DATA_W-1:0] sdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rcoef,
   output logic [DATA_W-1:0] rsamp
);

   logic [DATA_W-1:0] coef [TAPS];
   logic [DATA_W-1:0] hist [TAPS];

   // coefficient file write port
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) coef[k] <= '0;
      end else if (we) begin
         coef[waddr] <= wdata;
      end
   end

   // newest sample enters at index 0, older ones move up
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) hist[k] <= '0;
      end else if (shift) begin
         hist[0] <= sdata;
         for (int k = 1; k < TAPS; k++) hist[k] <= hist[k-1];
      end
   end

   assign rcoef = coef[raddr];
   assign rsamp = hist[raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences TAPS multiply-accumulate passes through the DSP
// slice per accepted sample and returns the final P.
module fir_mac_sequencer
   import fir_seq_pkg::*;
#(
   parameter int TAPS       = 8,
   parameter int P_LAT      = 3,
   parameter int OPMODE_LAG = 1,
   localparam int AW = $clog2(TAPS)
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              coef_we,
   input  logic [AW-1:0]     coef_addr,
   input  logic [DATA_W-1:0] coef_data,
   output logic [DATA_W-1:0] dsp_a,
   output logic [DATA_W-1:0] dsp_b,
   output logic [7:0]        dsp_opmode,
   input  logic [P_W-1:0]    dsp_p,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [P_W-1:0]    m_data,
   output logic              busy
);

   state_t            state, state_nxt;
   logic [AW-1:0]     cnt;
   logic [7:0]        dcnt;
   logic [DATA_W-1:0] rcoef, rsamp;
   logic [7:0]        opm_issue;
   logic              accept;
   logic              last_tap;
   logic              last_drain;

   assign accept     = (state == IDLE) && s_valid;
   assign last_tap   = (cnt == AW'(TAPS - 1));
   assign last_drain = (dcnt == 8'(P_LAT - 1));
   assign busy       = (state != IDLE);

   fir_tap_buffer #(.TAPS(TAPS)) u_buf (
      .clk   (clk),
      .rst   (RST),
      .we    (coef_we && (state == IDLE)),
      .waddr (coef_addr),
      .wdata (coef_data),
      .shift (accept),
      .sdata (s_data),
      .raddr (cnt),
      .rcoef (rcoef),
      .rsamp (rsamp)
   );

   // state register
   always_ff @(posedge clk) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state, operand issue and handshake
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      dsp_a     = '0;
      dsp_b     = '0;
      opm_issue = OPM_IDLE;
      unique case (state)
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) state_nxt = RUN;
         end
         RUN: begin
            dsp_a     = rcoef;
            dsp_b     = rsamp;
            opm_issue = (cnt == '0) ? OPM_MAC_FIRST : OPM_MAC_ACC;
            if (last_tap) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (last_drain) state_nxt = HOLD;
         end
         HOLD: begin
            if (m_ready) state_nxt = IDLE;
         end
      endcase
   end

   // tap and drain counters
   always_ff @(posedge clk) begin
      if (RST) begin
         cnt  <= '0;
         dcnt <= '0;
      end else begin
         cnt  <= (state == RUN) ? cnt + 1'b1 : '0;
         dcnt <= (state == DRAIN) ? dcnt + 8'd1 : 8'd0;
      end
   end

   // result capture and output handshake
   always_ff @(posedge clk) begin
      if (RST) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (state == DRAIN && last_drain) begin
         m_valid <= 1'b1;
         m_data  <= dsp_p;
      end else if (state == HOLD && m_ready) begin
         m_valid <= 1'b0;
      end
   end

   // OPMODE trails its operands by OPMODE_LAG cycles
   if (OPMODE_LAG == 0) begin : g_nolag
      assign dsp_opmode = opm_issue;
   end else begin : g_lag
      logic [7:0] q [OPMODE_LAG];
      always_ff @(posedge clk) begin
         if (RST) begin
            for (int i = 0; i < OPMODE_LAG; i++) q[i] <= OPM_IDLE;
         end else begin
            q[0] <= opm_issue;
            for (int i = 1; i < OPMODE_LAG; i++) q[i] <= q[i-1];
         end
      end
      assign dsp_opmode = q[OPMODE_LAG-1];
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer with TAPS=4 and a DSP slice
// model (A1/B1, M, OPMODE and P registers).
module tb_fir_mac_sequencer;

   localparam int TAPS  = 4;
   localparam int P_LAT = 3;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [17:0] s_data = '0;
   logic        coef_we = 1'b0;
   logic [1:0]  coef_addr = '0;
   logic [17:0] coef_data = '0;
   logic [17:0] dsp_a, dsp_b;
   logic [7:0]  dsp_opmode;
   logic [47:0] dsp_p;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [47:0] m_data;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [17:0] m_coef [TAPS];
   logic [17:0] m_hist [TAPS];
   logic [47:0] sb [$];
   logic [47:0] last_md;

   always #5 clk = ~clk;

   fir_mac_sequencer #(
      .TAPS(TAPS), .P_LAT(P_LAT), .OPMODE_LAG(1)
   ) dut (
      .clk(clk), .RST(RST),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
      .dsp_p(dsp_p),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .busy(busy)
   );

   // slice model: A1/B1 -> M -> P, OPMODE registered once
   logic [17:0] a1 = '0, b1 = '0;
   logic [35:0] m_r = '0;
   logic [7:0]  opm_r = '0;
   logic [47:0] p_r = '0;
   always @(posedge clk) begin
      a1    <= dsp_a;
      b1    <= dsp_b;
      m_r   <= {18'd0, a1} * {18'd0, b1};
      opm_r <= dsp_opmode;
      p_r   <= ((opm_r[1:0] == 2'b01) ? {12'd0, m_r} : 48'd0)
             + ((opm_r[3:2] == 2'b10) ? p_r : 48'd0);
   end
   assign dsp_p = p_r;

   task automatic check(input string tag,
                        input logic [47:0] obs,
                        input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input int a, input logic [17:0] d);
      coef_we   = 1'b1;
      coef_addr = 2'(a);
      coef_data = d;
      tick();
      coef_we = 1'b0;
      m_coef[a] = d;
   endtask

   task automatic model_accept(input logic [17:0] d);
      logic [47:0] acc;
      for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = d;
      acc = '0;
      for (int k = 0; k < TAPS; k++)
         acc += {30'd0, m_coef[k]} * {30'd0, m_hist[k]};
      sb.push_back(acc);
   endtask

   // accept one sample, optionally with a coef write in the same cycle
   task automatic start(input logic [17:0] d, input bit we,
                        input int a, input logic [17:0] cd);
      check("s_ready_idle", 48'(s_ready), 48'd1);
      s_valid = 1'b1;
      s_data  = d;
      if (we) begin
         coef_we   = 1'b1;
         coef_addr = 2'(a);
         coef_data = cd;
         m_coef[a] = cd;
      end
      tick();
      s_valid = 1'b0;
      coef_we = 1'b0;
      model_accept(d);
   endtask

   // wait for the result, check latency and data, then drain it
   task automatic finish(input string tag, input int n0,
                         input bit early, input int hold);
      int n;
      logic [47:0] exp;
      n = n0;
      if (early) m_ready = 1'b1;
      while (!m_valid && n < 50) begin
         tick();
         n++;
      end
      exp = (sb.size() > 0) ? sb.pop_front() : 48'hx;
      if (!m_valid) begin
         check({tag, "_timeout"}, 48'(m_valid), 48'd1);
      end else begin
         check({tag, "_lat"}, 48'(n), 48'(TAPS + P_LAT));
         check(tag, m_data, exp);
         last_md = m_data;
         for (int i = 0; i < hold; i++) begin
            s_valid = 1'b1;
            s_data  = 18'd999;
            tick();
            check({tag, "_hold_mv"}, 48'(m_valid), 48'd1);
            check({tag, "_hold_md"}, m_data, last_md);
            check({tag, "_hold_srdy"}, 48'(s_ready), 48'd0);
         end
         s_valid = 1'b0;
         m_ready = 1'b1;
         tick();
         m_ready = 1'b0;
         check({tag, "_mv_clr"}, 48'(m_valid), 48'd0);
      end
   endtask

   initial begin
      for (int k = 0; k < TAPS; k++) begin
         m_coef[k] = '0;
         m_hist[k] = '0;
      end
      last_md = '0;

      // reset state
      tick();
      tick();
      check("rst_srdy", 48'(s_ready), 48'd1);
      check("rst_mv", 48'(m_valid), 48'd0);
      check("rst_md", m_data, 48'd0);
      check("rst_busy", 48'(busy), 48'd0);
      check("rst_a", 48'(dsp_a), 48'd0);
      check("rst_opm", 48'(dsp_opmode), 48'd0);
      RST = 1'b0;
      tick();

      // coefs 1..4, single sample
      for (int k = 0; k < TAPS; k++) write_coef(k, 18'(k + 1));
      start(18'd10, 1'b0, 0, '0);
      check("run_busy", 48'(busy), 48'd1);
      finish("single", 0, 1'b0, 0);
      check("single_val", last_md, 48'd10);

      // stream of samples
      start(18'd20, 1'b0, 0, '0);
      finish("seq20", 0, 1'b0, 0);
      start(18'd30, 1'b0, 0, '0);
      finish("seq30", 0, 1'b0, 0);
      start(18'd40, 1'b0, 0, '0);
      finish("seq40", 0, 1'b0, 0);
      check("seq_val", last_md, 48'd200);

      // back-pressure: result held, no accepts
      start(18'd50, 1'b0, 0, '0);
      finish("hold", 0, 1'b0, 20);

      // full-scale operands, m_ready already high at capture
      for (int k = 0; k < TAPS; k++) write_coef(k, 18'h3FFFF);
      for (int i = 0; i < 4; i++) begin
         start(18'h3FFFF, 1'b0, 0, '0);
         finish("max", 0, (i == 3), 0);
      end
      check("max_val", last_md, 48'h003FFFE00004);

      // coef write during RUN is ignored
      for (int k = 0; k < TAPS; k++) write_coef(k, 18'(k + 5));
      start(18'd1, 1'b0, 0, '0);
      coef_we   = 1'b1;
      coef_addr = 2'd0;
      coef_data = 18'd100;
      tick();
      coef_we = 1'b0;
      finish("we_run", 1, 1'b0, 0);

      // coef write in the accepting cycle lands first
      start(18'd2, 1'b1, 0, 18'd100);
      finish("we_idle", 0, 1'b0, 0);

      // reset in DRAIN aborts the job
      start(18'd7, 1'b0, 0, '0);
      for (int i = 0; i < 5; i++) tick();
      check("drain_busy", 48'(busy), 48'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      sb.delete();
      for (int k = 0; k < TAPS; k++) begin
         m_coef[k] = '0;
         m_hist[k] = '0;
      end
      check("abort_busy", 48'(busy), 48'd0);
      for (int i = 0; i < 12; i++) begin
         check("abort_mv", 48'(m_valid), 48'd0);
         tick();
      end
      start(18'd77, 1'b0, 0, '0);
      finish("post_rst", 0, 1'b0, 0);
      check("post_rst_val", last_md, 48'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
